// File: rtl/lenet_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// lenet_cmd_ctrl_if
//   Bundle of every signal between the host command sequencer and its
//   neighbours: UART_RX byte stream, UART_TX byte handshake, the LeNet core
//   buffer-memory port and the core start/busy pair.
//
//   master : the command sequencer (lenet_cmd_ctrl)
//   slave  : the environment (UART_RX/UART_TX, memory, core)
//
//   Signals (direction seen from the master):
//     i_rx_dv      in   1   one-cycle strobe, i_rx_byte valid
//     i_rx_byte    in   8   received byte
//     o_tx_dv      out  1   one-cycle strobe, load o_tx_byte into UART_TX
//     o_tx_byte    out  8   byte to transmit
//     i_tx_done    in   1   one-cycle strobe, UART_TX finished its byte
//     o_mem_addr   out  AW  memory address
//     o_mem_wdata  out  8   memory write data
//     o_mem_we     out  1   write strobe
//     o_mem_re     out  1   read strobe, i_mem_rdata valid one cycle later
//     i_mem_rdata  in   8   memory read data
//     o_acc_start  out  1   core start pulse
//     i_acc_busy   in   1   core running, memory belongs to the core
//     o_err        out  1   one-cycle error pulse
// ---------------------------------------------------------------------------
interface lenet_cmd_ctrl_if #(
    parameter int unsigned AW = 16
);
    logic          i_rx_dv;
    logic [7:0]    i_rx_byte;
    logic          o_tx_dv;
    logic [7:0]    o_tx_byte;
    logic          i_tx_done;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    o_mem_wdata;
    logic          o_mem_we;
    logic          o_mem_re;
    logic [7:0]    i_mem_rdata;
    logic          o_acc_start;
    logic          i_acc_busy;
    logic          o_err;

    modport master (
        input  i_rx_dv, i_rx_byte, i_tx_done, i_mem_rdata, i_acc_busy,
        output o_tx_dv, o_tx_byte, o_mem_addr, o_mem_wdata, o_mem_we,
               o_mem_re, o_acc_start, o_err
    );

    modport slave (
        output i_rx_dv, i_rx_byte, i_tx_done, i_mem_rdata, i_acc_busy,
        input  o_tx_dv, o_tx_byte, o_mem_addr, o_mem_wdata, o_mem_we,
               o_mem_re, o_acc_start, o_err
    );
endinterface

// File: rtl/lenet_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// lenet_cmd_ctrl
//   Host command sequencer between UART_RX/UART_TX and the LeNet core.
//   Parses framed byte commands  HEAD CMD [args]:
//     CMD_WR  ADDR_H ADDR_L DATA  -> one memory write
//     CMD_GO                      -> one core start pulse
//     CMD_RD  ADDR_H ADDR_L       -> READ_LEN memory reads, each byte sent
//                                    to UART_TX and acknowledged before the
//                                    next read is issued
//   The memory port and the start pulse are used only while the core is
//   idle. Bytes outside a frame are dropped; a stalled frame times out.
//
//   Ports:
//     clk      in  system clock
//     reset_n  in  synchronous active-low reset
//     bus      lenet_cmd_ctrl_if.master (UART, memory and core signals)
// ---------------------------------------------------------------------------
module lenet_cmd_ctrl #(
    parameter int unsigned AW           = 16,
    parameter int unsigned READ_LEN     = 16,
    parameter int unsigned TIMEOUT_CLKS = 100000,
    parameter logic [7:0]  HEAD         = 8'h23,
    parameter logic [7:0]  CMD_WR       = 8'h09,
    parameter logic [7:0]  CMD_GO       = 8'h14,
    parameter logic [7:0]  CMD_RD       = 8'h04
) (
    input logic               clk,
    input logic               reset_n,
    lenet_cmd_ctrl_if.master  bus
);

    // Idle-cycle counter only has to reach TIMEOUT_CLKS-1.
    localparam int unsigned TOW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADR_H, S_ADR_L, S_DATA, S_WRITE,
        S_GO, S_RD_REQ, S_RD_LAT, S_TX, S_TX_WAIT
    } state_t;

    state_t           state_q,   state_d;
    logic [7:0]       addr_hi_q, addr_hi_d;
    logic [AW-1:0]    addr_q,    addr_d;
    logic [7:0]       wdata_q,   wdata_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             is_rd_q,   is_rd_d;
    logic [15:0]      cnt_q,     cnt_d;
    logic [TOW-1:0]   to_q,      to_d;

    logic             in_frame;
    logic             timeout_hit;
    logic             bad_cmd;

    logic             tx_dv;
    logic             mem_we;
    logic             mem_re;
    logic             acc_start;
    logic             err;

    // Two address bytes always arrive; bits above AW-1 are discarded.
    function automatic logic [AW-1:0] frame_addr(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] full;
        full = {hi, lo};
        return AW'(full);
    endfunction

    // Only the argument-collecting states are subject to the byte timeout.
    assign in_frame    = (state_q == S_CMD)   || (state_q == S_ADR_H) ||
                         (state_q == S_ADR_L) || (state_q == S_DATA);
    assign timeout_hit = in_frame && !bus.i_rx_dv && (to_q == TO_LAST);
    // A repeated HEAD inside CMD is deliberately treated as an unknown command.
    assign bad_cmd     = (state_q == S_CMD) && bus.i_rx_dv &&
                         (bus.i_rx_byte != CMD_WR) && (bus.i_rx_byte != CMD_RD) &&
                         (bus.i_rx_byte != CMD_GO);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_hi_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_byte_q <= '0;
            is_rd_q   <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_hi_q <= addr_hi_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_byte_q <= tx_byte_d;
            is_rd_q   <= is_rd_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_hi_d = addr_hi_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_byte_d = tx_byte_q;
        is_rd_d   = is_rd_q;
        cnt_d     = cnt_q;

        // Counts idle cycles inside a frame; any received byte restarts it.
        if (in_frame && !bus.i_rx_dv && !timeout_hit) begin
            to_d = to_q + TOW'(1);
        end else begin
            to_d = '0;
        end

        if (timeout_hit) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_rx_dv && (bus.i_rx_byte == HEAD)) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.i_rx_dv) begin
                        if (bus.i_rx_byte == CMD_WR) begin
                            is_rd_d = 1'b0;
                            state_d = S_ADR_H;
                        end else if (bus.i_rx_byte == CMD_RD) begin
                            is_rd_d = 1'b1;
                            state_d = S_ADR_H;
                        end else if (bus.i_rx_byte == CMD_GO) begin
                            state_d = S_GO;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_ADR_H: begin
                    if (bus.i_rx_dv) begin
                        addr_hi_d = bus.i_rx_byte;
                        state_d   = S_ADR_L;
                    end
                end
                S_ADR_L: begin
                    if (bus.i_rx_dv) begin
                        addr_d = frame_addr(addr_hi_q, bus.i_rx_byte);
                        if (is_rd_q) begin
                            cnt_d   = 16'(READ_LEN);
                            state_d = S_RD_REQ;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.i_rx_dv) begin
                        wdata_d = bus.i_rx_byte;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE, S_GO: begin
                    state_d = S_IDLE;
                end
                S_RD_REQ: begin
                    // Wait here for the core to release memory; no timeout.
                    if (!bus.i_acc_busy) begin
                        state_d = S_RD_LAT;
                    end
                end
                S_RD_LAT: begin
                    tx_byte_d = bus.i_mem_rdata;
                    state_d   = S_TX;
                end
                S_TX: begin
                    state_d = S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (bus.i_tx_done) begin
                        addr_d = addr_q + AW'(1);
                        cnt_d  = cnt_q - 16'd1;
                        state_d = (cnt_q == 16'd1) ? S_IDLE : S_RD_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------------
    always_comb begin
        tx_dv     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        acc_start = 1'b0;
        err       = 1'b0;
        // Strobes are held low throughout a reset cycle.
        if (reset_n) begin
            unique case (state_q)
                S_WRITE: begin
                    mem_we = !bus.i_acc_busy;
                    err    = bus.i_acc_busy;
                end
                S_GO: begin
                    acc_start = !bus.i_acc_busy;
                    err       = bus.i_acc_busy;
                end
                S_RD_REQ: begin
                    mem_re = !bus.i_acc_busy;
                end
                S_TX: begin
                    tx_dv = 1'b1;
                end
                default: begin
                    err = bad_cmd || timeout_hit;
                end
            endcase
        end
    end

    assign bus.o_tx_dv     = tx_dv;
    assign bus.o_tx_byte   = tx_byte_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_re    = mem_re;
    assign bus.o_acc_start = acc_start;
    assign bus.o_err       = err;

endmodule
